// File: rtl/ram_free_rom_seq.sv
// Burst ROM reader: one word issued per cycle; word i = i ^ 'hA5, zero past DEPTH-1.
// Latency: rd_valid one cycle after issue (two with ROM_SEQ_OUTREG_EN).
// Backpressure: none; requests are ignored while busy.
module ram_free_rom_seq #(
    parameter int    WIDTH     = 8,
    parameter int    DEPTH     = 16,
    parameter string INIT_FILE = "",
    localparam int   AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd_req,
    input  logic [AW-1:0]    rd_addr,
    input  logic [AW-1:0]    rd_len,
    output logic             busy,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_last
);

    typedef enum logic {S_IDLE = 1'b0, S_BURST = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [AW-1:0]    remain_q, remain_d;
    logic             busy_q;

    logic             iss_vld;
    logic             iss_last;
    logic [AW-1:0]    iss_addr;
    logic             iss_in_rng;
    logic [WIDTH-1:0] rom_word;
    logic [WIDTH-1:0] iss_dat;

    logic             v1_q, l1_q;
    logic [WIDTH-1:0] d1_q;
`ifdef ROM_SEQ_OUTREG_EN
    logic             v2_q, l2_q;
    logic [WIDTH-1:0] d2_q;
`endif

    function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
        if (int'(a) == DEPTH - 1) return '0;
        return a + AW'(1);
    endfunction

    function automatic logic [WIDTH-1:0] pattern(input logic [AW-1:0] a);
        logic [63:0] w;
        w = 64'(a) ^ 64'hA5;
        return w[WIDTH-1:0];
    endfunction

    assign rom_word = pattern(iss_addr);

    // Addresses past the last word exist when DEPTH is not a power of two; they read as zero.
    assign iss_in_rng = (int'(iss_addr) < DEPTH);
    assign iss_dat    = iss_in_rng ? rom_word : '0;

    always_comb begin
        iss_vld  = 1'b0;
        iss_last = 1'b0;
        iss_addr = addr_q;
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        case (state_q)
            S_IDLE: begin
                if (rd_req && !busy_q) begin
                    iss_vld  = 1'b1;
                    iss_addr = rd_addr;
                    iss_last = (rd_len == '0);
                    addr_d   = addr_inc(rd_addr);
                    remain_d = rd_len - AW'(1);
                    if (rd_len != '0) state_d = S_BURST;
                end
            end
            S_BURST: begin
                iss_vld  = 1'b1;
                iss_addr = addr_q;
                iss_last = (remain_q == '0);
                addr_d   = addr_inc(addr_q);
                remain_d = remain_q - AW'(1);
                if (remain_q == '0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            busy_q   <= 1'b0;
            v1_q     <= 1'b0;
            l1_q     <= 1'b0;
            d1_q     <= '0;
`ifdef ROM_SEQ_OUTREG_EN
            v2_q     <= 1'b0;
            l2_q     <= 1'b0;
            d2_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            v1_q     <= iss_vld;
            l1_q     <= iss_last;
            if (iss_vld) d1_q <= iss_dat;
`ifdef ROM_SEQ_OUTREG_EN
            // Busy covers both the issue slot and the word sitting in the first stage.
            busy_q   <= iss_vld | v1_q;
            v2_q     <= v1_q;
            l2_q     <= l1_q;
            if (v1_q) d2_q <= d1_q;
`else
            busy_q   <= iss_vld;
`endif
        end
    end

    assign busy = busy_q;
`ifdef ROM_SEQ_OUTREG_EN
    assign rd_valid = v2_q;
    assign rd_last  = l2_q;
    assign rd_data  = d2_q;
`else
    assign rd_valid = v1_q;
    assign rd_last  = l1_q;
    assign rd_data  = d1_q;
`endif

endmodule
